// File: rtl/dout_tx_if.sv
// dout_tx_if: DOUT write port and FLAG-set return path between the CPU and the serial transmitter
//   tx_data[7:0]  byte written to DOUT (register-file write-data bus)
//   tx_wr         one-cycle DOUT write strobe
//   tx            serial line, idles high
//   busy          frame in progress
//   flag_out[7:0] one-cycle DONE / OVR pulses for the FLAG set-inputs
interface dout_tx_if;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx;
    logic       busy;
    logic [7:0] flag_out;
    modport master (output tx_data, tx_wr, input tx, busy, flag_out);
    modport slave  (input tx_data, tx_wr, output tx, busy, flag_out);
endinterface

// File: rtl/dout_serial_tx.sv
// dout_serial_tx: 8N1 UART transmitter fed by DOUT writes, pulsing FLAG bits on completion/overrun
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   bus    dout_tx_if.slave: tx_data, tx_wr in; tx, busy, flag_out out
//   Optional macro DOUT_TX_BUFFER_EN adds a one-byte holding buffer for back-to-back frames.
module dout_serial_tx #(
    parameter int CLKS_PER_BIT  = 434,
    parameter int DONE_FLAG_BIT = 6,
    parameter int OVR_FLAG_BIT  = 5
) (
    input logic clk,
    input logic reset,
    dout_tx_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] bit_idx, bit_n;
    logic [7:0] shreg, shreg_n;
    logic tx_r, tx_n, done_r, done_n, ovr_r, ovr_n, bit_end;
`ifdef DOUT_TX_BUFFER_EN
    logic [7:0] hold, hold_n;
    logic full, full_n;
`endif
    assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
    always_comb begin
        state_n = state;
        cnt_n   = (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
        bit_n   = bit_idx;
        shreg_n = shreg;
        tx_n    = tx_r;
        done_n  = 1'b0;
        ovr_n   = 1'b0;
`ifdef DOUT_TX_BUFFER_EN
        hold_n  = hold;
        full_n  = full;
`endif
        case (state)
            IDLE: if (bus.tx_wr) begin
                state_n = START;
                shreg_n = bus.tx_data;
                tx_n    = 1'b0;
            end
            START: if (bit_end) begin
                state_n = DATA;
                tx_n    = shreg[0];
            end
            DATA: if (bit_end) begin
                if (bit_idx == 3'd7) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                    bit_n   = 3'd0;
                end else begin
                    bit_n   = bit_idx + 3'd1;
                    tx_n    = shreg[bit_idx + 3'd1];
                end
            end
            STOP: if (bit_end) begin
                done_n  = 1'b1;
                state_n = IDLE;
                tx_n    = 1'b1;
`ifdef DOUT_TX_BUFFER_EN
                // Chain straight into the next start bit, no idle bit in between.
                if (full) begin
                    state_n = START;
                    shreg_n = hold;
                    tx_n    = 1'b0;
                    full_n  = 1'b0;
                end else if (bus.tx_wr) begin
                    state_n = START;
                    shreg_n = bus.tx_data;
                    tx_n    = 1'b0;
                end
`endif
            end
        endcase
        if (bus.tx_wr && state != IDLE) begin
`ifdef DOUT_TX_BUFFER_EN
            // Old full flag decides: a write landing as the buffer drains is still an overrun.
            if (full)
                ovr_n = 1'b1;
            else if (!(state == STOP && bit_end)) begin
                hold_n = bus.tx_data;
                full_n = 1'b1;
            end
`else
            ovr_n = 1'b1;
`endif
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
            tx_r    <= 1'b1;
            done_r  <= 1'b0;
            ovr_r   <= 1'b0;
`ifdef DOUT_TX_BUFFER_EN
            hold    <= 8'd0;
            full    <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shreg   <= shreg_n;
            tx_r    <= tx_n;
            done_r  <= done_n;
            ovr_r   <= ovr_n;
`ifdef DOUT_TX_BUFFER_EN
            hold    <= hold_n;
            full    <= full_n;
`endif
        end
    end
    assign bus.tx   = tx_r;
    assign bus.busy = state != IDLE;
    always_comb begin
        bus.flag_out = 8'd0;
        bus.flag_out[DONE_FLAG_BIT] = done_r;
        bus.flag_out[OVR_FLAG_BIT]  = ovr_r;
    end
endmodule

// File: tb/tb_dout_serial_tx.sv
// tb_dout_serial_tx: per-cycle check of dout_serial_tx against a frame-timing reference model
module tb_dout_serial_tx;
    localparam int C = 4;
    logic clk = 1'b0;
    logic reset;
    dout_tx_if ifc ();
    dout_serial_tx #(.CLKS_PER_BIT(C)) dut (.clk(clk), .reset(reset), .bus(ifc));
    always #5 clk = ~clk;
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic act = 1'b0;
    int n0 = 0;
    logic [7:0] mbyte = 8'd0;
    logic hfull = 1'b0;
    logic [7:0] hbyte = 8'd0;
    task automatic step(input logic r, input logic w, input logic [7:0] d);
        int p, q, j;
        logic busy_p, fin, done, ovr, was_full, etx, ebusy;
        logic [7:0] eflag;
        reset = r;
        ifc.tx_wr = w;
        ifc.tx_data = d;
        p = cyc;
        busy_p = act && p >= n0 + 1 && p <= n0 + 10 * C;
        fin = act && p == n0 + 10 * C;
        done = 1'b0;
        ovr = 1'b0;
        if (r) begin
            act = 1'b0;
            hfull = 1'b0;
        end else begin
            if (fin) begin
                done = 1'b1;
                act = 1'b0;
            end
            was_full = hfull;
`ifdef DOUT_TX_BUFFER_EN
            if (fin && hfull) begin
                act = 1'b1; n0 = p; mbyte = hbyte; hfull = 1'b0;
            end
            if (w) begin
                if (!busy_p) begin
                    act = 1'b1; n0 = p; mbyte = d;
                end else if (was_full) ovr = 1'b1;
                else if (fin) begin
                    act = 1'b1; n0 = p; mbyte = d;
                end else begin
                    hbyte = d; hfull = 1'b1;
                end
            end
`else
            if (w) begin
                if (busy_p) ovr = 1'b1;
                else begin
                    act = 1'b1; n0 = p; mbyte = d;
                end
            end
`endif
        end
        @(posedge clk);
        cyc++;
        #1;
        q = cyc;
        etx = 1'b1;
        ebusy = 1'b0;
        if (act && q >= n0 + 1 && q <= n0 + 10 * C) begin
            ebusy = 1'b1;
            j = (q - n0 - 1) / C;
            etx = (j == 0) ? 1'b0 : (j <= 8) ? mbyte[j-1] : 1'b1;
        end
        eflag = 8'd0;
        eflag[6] = done;
        eflag[5] = ovr;
        vectors++;
        assert (ifc.tx === etx) else begin
            miscompares++;
            $error("FAIL tx cyc=%0d got %b exp %b", q, ifc.tx, etx);
        end
        vectors++;
        assert (ifc.busy === ebusy) else begin
            miscompares++;
            $error("FAIL busy cyc=%0d got %b exp %b", q, ifc.busy, ebusy);
        end
        vectors++;
        assert (ifc.flag_out === eflag) else begin
            miscompares++;
            $error("FAIL flag_out cyc=%0d got %h exp %h", q, ifc.flag_out, eflag);
        end
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask
    initial begin
        reset = 1'b1;
        ifc.tx_wr = 1'b0;
        ifc.tx_data = 8'h00;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'hFF);
        idle(20);
        step(1'b0, 1'b1, 8'hA5);
        idle(50);
        step(1'b0, 1'b1, 8'h3C);
        idle(19);
        step(1'b0, 1'b1, 8'h81);
        idle(30);
        step(1'b0, 1'b1, 8'h01);
        idle(40);
        step(1'b0, 1'b1, 8'h02);
        idle(50);
        step(1'b0, 1'b1, 8'hFF);
        idle(14);
        step(1'b1, 1'b0, 8'h00);
        idle(60);
        step(1'b0, 1'b1, 8'h5A);
        idle(39);
        step(1'b0, 1'b1, 8'hC3);
        idle(50);
`ifdef DOUT_TX_BUFFER_EN
        step(1'b0, 1'b1, 8'h11);
        idle(4);
        step(1'b0, 1'b1, 8'h22);
        step(1'b0, 1'b1, 8'h33);
        idle(90);
`endif
        for (int i = 0; i < 2500; i++)
            step($urandom_range(0, 499) == 0, $urandom_range(0, 19) == 0, 8'($urandom));
        idle(50);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
